// File: rtl/dvfs_transition_sequencer.sv
// rtl/dvfs_transition_sequencer.sv - orders voltage/frequency moves for one power domain
// Voltage rises before frequency and falls after it; frequency moves one PLL-locked step at a time.
module dvfs_transition_sequencer #(
    parameter int V_SETTLE_CYC = 16,
    parameter int LOCK_TIMEOUT = 64,
    parameter int TW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_v,
    input  logic [2:0] req_f,
    output logic       req_ready,
    input  logic       pll_lock,
    output logic [1:0] v_out,
    output logic [2:0] f_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_UP,
        S_F_STEP,
        S_F_WAIT,
        S_V_DOWN,
        S_DONE
    } state_t;

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(V_SETTLE_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE       = TW'(1);

    state_t          state_q, state_d;
    logic [1:0]      v_q, v_d;
    logic [2:0]      f_q, f_d;
    logic [1:0]      tgt_v_q, tgt_v_d;
    logic [2:0]      tgt_f_q, tgt_f_d;
    logic [2:0]      prev_f_q, prev_f_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_flag_q, err_flag_d;
    logic            resolve;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            v_q        <= 2'b01;
            f_q        <= 3'b010;
            tgt_v_q    <= 2'b01;
            tgt_f_q    <= 3'b010;
            prev_f_q   <= 3'b010;
            timer_q    <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            f_q        <= f_d;
            tgt_v_q    <= tgt_v_d;
            tgt_f_q    <= tgt_f_d;
            prev_f_q   <= prev_f_d;
            timer_q    <= timer_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        f_d        = f_q;
        tgt_v_d    = tgt_v_q;
        tgt_f_d    = tgt_f_q;
        prev_f_d   = prev_f_q;
        timer_d    = timer_q;
        err_flag_d = err_flag_q;
        resolve    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tgt_v_d = req_v;
                    tgt_f_d = req_f;
                    if (req_v > v_q) begin
                        state_d = S_V_UP;
                        v_d     = req_v;
                        timer_d = SETTLE_LOAD;
                    end else if (req_f != f_q) begin
                        state_d = S_F_STEP;
                    end else if (req_v < v_q) begin
                        state_d = S_V_DOWN;
                        v_d     = req_v;
                        timer_d = SETTLE_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_V_UP: begin
                if (timer_q == '0) begin
                    resolve = 1'b1;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_F_STEP: begin
                prev_f_d = f_q;
                f_d      = (tgt_f_q > f_q) ? f_q + 3'd1 : f_q - 3'd1;
                timer_d  = LOCK_LOAD;
                state_d  = S_F_WAIT;
            end
            S_F_WAIT: begin
                // The timer still holds its load value only in the first wait cycle, which is blanked.
                if (pll_lock && (timer_q != LOCK_LOAD)) begin
                    resolve = 1'b1;
                end else if (timer_q == '0) begin
                    f_d        = prev_f_q;
                    err_flag_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_V_DOWN: begin
                if (timer_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_DONE: begin
                err_flag_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common exit once voltage has settled upward or a frequency step has locked.
        if (resolve) begin
            if (tgt_f_q != f_q) begin
                state_d = S_F_STEP;
            end else if (tgt_v_q < v_q) begin
                state_d = S_V_DOWN;
                v_d     = tgt_v_q;
                timer_d = SETTLE_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_flag_q;
    assign v_out     = v_q;
    assign f_out     = f_q;

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// tb/tb_dvfs_transition_sequencer.sv - scoreboard bench for dvfs_transition_sequencer
module tb_dvfs_transition_sequencer;

    localparam int VS = 4;
    localparam int LT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_v = 2'd0;
    logic [2:0] req_f = 3'd0;
    logic       pll_lock = 1'b0;
    logic       req_ready;
    logic [1:0] v_out;
    logic [2:0] f_out;
    logic       busy;
    logic       done;
    logic       err;

    dvfs_transition_sequencer #(
        .V_SETTLE_CYC (VS),
        .LOCK_TIMEOUT (LT),
        .TW           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_v     (req_v),
        .req_f     (req_f),
        .req_ready (req_ready),
        .pll_lock  (pll_lock),
        .v_out     (v_out),
        .f_out     (f_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        logic [2:0] f;
        logic       e;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         lock_mode = 1;
    logic [1:0] mv;
    logic [2:0] mf;

    // Lock behaviour: 0 = never, 1 = always, 2 = only on the last wait cycle after an f_out change.
    logic [2:0] last_f = 3'b010;
    int         k = 255;
    always @(negedge clk) begin
        if (f_out != last_f) begin
            last_f = f_out;
            k = 1;
        end else if (k < 255) begin
            k = k + 1;
        end
        case (lock_mode)
            0:       pll_lock = 1'b0;
            1:       pll_lock = 1'b1;
            default: pll_lock = busy && (k == LT);
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic [1:0] tv, input logic [2:0] tf, input int mode,
                           input bit inject, input int rst_at);
        exp_t       e;
        logic       up;
        logic       down;
        int         steps;
        int         d;
        int         n;
        int         dcnt;
        logic [1:0] vhold;
        logic [2:0] pf;
        bit         seen;
        bit         injected;

        up    = (tv > mv);
        down  = (tv < mv);
        steps = (tf > mf) ? int'(tf) - int'(mf) : int'(mf) - int'(tf);
        e.v   = tv;
        e.f   = tf;
        e.e   = 1'b0;
        e.lat = 1 + (up ? VS : 0) + (down ? VS : 0) + steps * ((mode == 2) ? (1 + LT) : 3);
        if (mode == 0 && steps > 0) begin
            e.v   = up ? tv : mv;
            e.f   = mf;
            e.e   = 1'b1;
            e.lat = 1 + (up ? VS : 0) + 1 + LT;
        end
        sb_q.push_back(e);
        vhold = up ? tv : mv;
        pf    = mf;

        lock_mode = mode;
        @(negedge clk);
        req_v     = tv;
        req_f     = tf;
        req_valid = 1'b1;
        check("ready_idle", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;

        n        = 1;
        seen     = 1'b0;
        injected = 1'b0;
        while (!seen && n <= 200) begin
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                void'(sb_q.pop_back());
                check("rst_v", int'(v_out), 1);
                check("rst_f", int'(f_out), 2);
                check("rst_ready", int'(req_ready), 1);
                check("rst_busy", int'(busy), 0);
                dcnt = 0;
                repeat (12) begin
                    if (done) dcnt = dcnt + 1;
                    @(negedge clk);
                end
                check("rst_no_done", dcnt, 0);
                mv = 2'b01;
                mf = 3'b010;
                return;
            end
            if (n == 1) begin
                check("busy_run", int'(busy), 1);
                check("ready_run", int'(req_ready), 0);
                check("v_accept", int'(v_out), int'(vhold));
            end
            if (injected && req_valid) req_valid = 1'b0;
            if (f_out != pf) begin
                d = int'(f_out) - int'(pf);
                check("f_step", int'(d == 1 || d == -1), 1);
                check("v_order", int'(v_out), int'(vhold));
                if (inject && !injected) begin
                    req_v     = 2'd0;
                    req_f     = 3'd7;
                    req_valid = 1'b1;
                    injected  = 1'b1;
                end
                pf = f_out;
            end
            if (done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check("done_v", int'(v_out), int'(e.v));
                check("done_f", int'(f_out), int'(e.f));
                check("done_err", int'(err), int'(e.e));
                check("done_lat", n, e.lat);
            end else begin
                @(negedge clk);
                n = n + 1;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_front());
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("ready_after", int'(req_ready), 1);
        check("done_pulse", int'(done), 0);
        mv = e.v;
        mf = e.f;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_v", int'(v_out), 1);
        check("init_f", int'(f_out), 2);
        check("init_ready", int'(req_ready), 1);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_err", int'(err), 0);
        mv = 2'b01;
        mf = 3'b010;

        run_req(2'b01, 3'b010, 1, 1'b0, 0);   // no-op
        run_req(2'b11, 3'b101, 1, 1'b0, 0);   // scale up
        run_req(2'b00, 3'b000, 1, 1'b0, 0);   // scale down
        run_req(2'b10, 3'b010, 0, 1'b0, 0);   // lock timeout, voltage kept raised
        run_req(2'b10, 3'b001, 1, 1'b0, 0);   // clean request after error
        run_req(2'b11, 3'b100, 1, 1'b0, 2);   // reset during V_UP
        run_req(2'b11, 3'b011, 1, 1'b1, 0);   // busy request ignored
        run_req(2'b11, 3'b100, 2, 1'b0, 0);   // lock on timer-zero cycle
        run_req(2'b01, 3'b110, 1, 1'b0, 0);   // frequency up, voltage down

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dvfs_transition_sequencer.md
Name: dvfs_transition_sequencer

Overview:
- Sequences a safe voltage/frequency transition for one power domain (core or memory) when the DPM unit requests a new operating point.
- Ordering rules:
  - Raise voltage before raising frequency.
  - Lower frequency before lowering voltage.
  - Frequency moves one level per step, and each step is gated on PLL lock.
- One instance sits between the DPM state machine and each domain's regulator/PLL, so the DPM unit never drives V/F codes straight to hardware.

Parameters:
- V_SETTLE_CYC, 16, cycles the regulator needs to settle after any v_out change (must be >= 1).
- LOCK_TIMEOUT, 64, cycles allowed for pll_lock per frequency step, counted from F_WAIT entry (must be >= 2).
- TW, 8, timer width in bits; must satisfy 2^TW > max(V_SETTLE_CYC, LOCK_TIMEOUT).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  new operating point offered.
- req_v  in  2  target voltage code.
- req_f  in  3  target frequency code.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid && req_ready at a rising edge.
- pll_lock  in  1  PLL locked indication.
- v_out  out  2  voltage code to regulator (registered).
- f_out  out  3  frequency code to PLL (registered).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transition ends.
- err  out  1  valid with done; 1 = lock timeout occurred.

Behaviour:
- Reset:
  - state = IDLE, v_out = 2'b01, f_out = 3'b010, timer = 0, done = 0, err = 0.
  - busy = 0, req_ready = 1.
  - rst asserted mid-transition aborts immediately to these values; no done pulse is issued.
- States: IDLE, V_UP, F_STEP, F_WAIT, V_DOWN, DONE.
- IDLE, on accept:
  - Latch tgt_v = req_v and tgt_f = req_f.
  - Next state is chosen in priority order:
    - tgt_v > v_out -> V_UP, with v_out <= tgt_v and timer <= V_SETTLE_CYC-1 at the accept edge.
    - else tgt_f != f_out -> F_STEP.
    - else tgt_v < v_out -> V_DOWN, with v_out <= tgt_v and timer loaded.
    - else -> DONE (no-op request; done asserts the cycle after accept).
- V_UP:
  - Timer decrements each cycle; the state lasts exactly V_SETTLE_CYC cycles.
  - At timer == 0: go to F_STEP if tgt_f != f_out, else V_DOWN/DONE per the same rules.
- F_STEP (1 cycle):
  - Save prev_f = f_out.
  - f_out <= f_out+1 if tgt_f > f_out, else f_out-1 (saturating arithmetic is never needed, since 0..7 stays in range).
  - Timer <= LOCK_TIMEOUT-1; go to F_WAIT.
- F_WAIT:
  - pll_lock is ignored in the first F_WAIT cycle (blanking).
  - Qualified lock: go to F_STEP if f_out != tgt_f; else V_DOWN if tgt_v < v_out (v_out <= tgt_v, timer loaded); else DONE.
  - Timer reaching 0 without qualified lock:
    - f_out <= prev_f, set err_flag, go to DONE.
    - Voltage is left at its current (higher or equal) value; the pending voltage lowering is skipped.
  - Lock and timer-zero in the same cycle: lock wins.
- V_DOWN:
  - Timer-driven, identical to V_UP; then DONE.
- DONE (1 cycle):
  - done = 1 and err = err_flag.
  - Clear err_flag, then return to IDLE.
  - req_ready rises the cycle after done.
- Handshake:
  - req_valid while busy is ignored; nothing is latched and there is no queueing.
  - The requester must hold req_valid until it sees req_ready.
- Invariant: v_out is never lower than the value it had when any f_out increase was issued.
- Codes are unsigned; comparisons are unsigned. No other arithmetic beyond ±1 on f_out and the timer decrement.

Test Plan:
- Reset and no-op: after rst, check v_out = 01, f_out = 010, req_ready = 1. Then request v = 01, f = 010 -> done = 1 with err = 0 one cycle after accept; v_out/f_out unchanged.
- Scale-up (V_SETTLE_CYC = 4): request v = 11, f = 101 with pll_lock tied high.
  - v_out = 11 at the accept edge.
  - f_out stays 010 for 4 cycles.
  - f_out then steps 011, 100, 101, each step waiting >= 2 cycles.
  - Single done pulse with err = 0.
- Scale-down from v = 11, f = 101 to v = 00, f = 000:
  - f_out walks down to 000 before v_out changes.
  - v_out = 00, then 4 settle cycles, then done.
- Lock timeout (LOCK_TIMEOUT = 8): request f up by 2 with pll_lock held low.
  - f_out goes 010 -> 011, then reverts to 010 after 8 cycles.
  - done = 1 with err = 1; v_out stays at the raised value.
  - The next clean request reports err = 0.
- Busy rejection and mid-transition reset:
  - req_valid pulsed during F_WAIT is not accepted; tgt is unchanged.
  - rst asserted in V_UP returns v_out = 01, f_out = 010, IDLE next cycle, with no done pulse.
- Lock/timeout collision: pll_lock first rises exactly on the timer-zero cycle -> step is accepted and err = 0.
